// File: rtl/ff_mem_bank_be.sv
`default_nettype none
// ============================================================================
// Module   : ff_mem_bank_be
// Purpose  : Flip-flop memory bank, one write port with byte enables and one
//            registered read port. Configurable read/write collision policy,
//            out-of-range pulse and sticky error flag.
// Revision : 1.0 - initial release
// ============================================================================
module ff_mem_bank_be #(
    parameter int DATA_W        = 32,
    parameter int DEPTH         = 16,
    parameter int ADDR_W        = $clog2(DEPTH),
    parameter int WRITE_THROUGH = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [DATA_W/8-1:0]   wr_be,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_valid,
    output logic                  err_oob,
    output logic                  err_sticky,
    input  logic                  err_clr
);

    localparam int              NB      = DATA_W / 8;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    // Reject illegal configurations at elaboration time.
    generate
        if ((DATA_W % 8) != 0) begin : g_chk_width
            $error("ff_mem_bank_be: DATA_W must be a multiple of 8");
        end
        if (DEPTH < 2) begin : g_chk_depth
            $error("ff_mem_bank_be: DEPTH must be at least 2");
        end
        if ((2 ** ADDR_W) < DEPTH) begin : g_chk_addr
            $error("ff_mem_bank_be: ADDR_W too small for DEPTH");
        end
    endgenerate

    logic              wr_in_range;
    logic              rd_in_range;
    logic              wr_ok;
    logic              rd_ok;
    logic              hit;
    logic              oob;
    logic [DEPTH-1:0]  wr_sel;
    logic [DATA_W-1:0] rd_next;
    logic [DATA_W-1:0] mem [DEPTH];

    // Range checks compare against the true depth; addresses are never wrapped.
    assign wr_in_range = {1'b0, wr_addr} < DEPTH_L;
    assign rd_in_range = {1'b0, rd_addr} < DEPTH_L;
    assign wr_ok       = wr_en && wr_in_range;
    assign rd_ok       = rd_en && rd_in_range;
    assign hit         = wr_ok && rd_ok && (wr_addr == rd_addr);
    assign oob         = (wr_en && !wr_in_range) || (rd_en && !rd_in_range);

    // One-hot word select for the write port.
    generate
        for (genvar w = 0; w < DEPTH; w++) begin : g_dec
            assign wr_sel[w] = wr_ok && (wr_addr == ADDR_W'(w));
        end
    endgenerate

    // Storage: byte-lane updates on the selected word, full clear on reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int w = 0; w < DEPTH; w++) begin
                mem[w] <= '0;
            end
        end else begin
            for (int w = 0; w < DEPTH; w++) begin
                for (int b = 0; b < NB; b++) begin
                    if (wr_sel[w] && wr_be[b]) begin
                        mem[w][b*8 +: 8] <= wr_data[b*8 +: 8];
                    end
                end
            end
        end
    end

    // Read word selection; a colliding write is forwarded lane by lane when
    // write-through is enabled, otherwise the pre-write word is returned.
    always_comb begin
        rd_next = '0;
        if (rd_ok) begin
            rd_next = mem[rd_addr];
            if ((WRITE_THROUGH != 0) && hit) begin
                for (int b = 0; b < NB; b++) begin
                    if (wr_be[b]) begin
                        rd_next[b*8 +: 8] = wr_data[b*8 +: 8];
                    end
                end
            end
        end
    end

    // Registered read response and error flags; set beats clear on the sticky bit.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            err_oob    <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            rd_data  <= rd_next;
            rd_valid <= rd_en;
            err_oob  <= oob;
            if (oob) begin
                err_sticky <= 1'b1;
            end else if (err_clr) begin
                err_sticky <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ff_mem_bank_be.sv
`default_nettype none
// ============================================================================
// Module   : tb_ff_mem_bank_be
// Purpose  : Self-checking bench for ff_mem_bank_be. Instance 0 is the default
//            configuration (32 bits x 16, write-through); instance 1 is
//            32 bits x 6 with a 3-bit address and read-old-data collisions.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ff_mem_bank_be;

    logic        clk = 1'b0;
    logic        resetn;
    logic        wr_en   [2];
    logic [3:0]  wr_addr [2];
    logic [31:0] wr_data [2];
    logic [3:0]  wr_be   [2];
    logic        rd_en   [2];
    logic [3:0]  rd_addr [2];
    logic        err_clr [2];
    logic [31:0] rd_data    [2];
    logic        rd_valid   [2];
    logic        err_oob    [2];
    logic        err_sticky [2];

    int checks = 0;
    int errors = 0;

    ff_mem_bank_be #(.DATA_W(32), .DEPTH(16), .ADDR_W(4), .WRITE_THROUGH(1)) dut_a (
        .clk(clk), .resetn(resetn),
        .wr_en(wr_en[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]), .wr_be(wr_be[0]),
        .rd_en(rd_en[0]), .rd_addr(rd_addr[0]),
        .rd_data(rd_data[0]), .rd_valid(rd_valid[0]),
        .err_oob(err_oob[0]), .err_sticky(err_sticky[0]), .err_clr(err_clr[0])
    );

    ff_mem_bank_be #(.DATA_W(32), .DEPTH(6), .ADDR_W(3), .WRITE_THROUGH(0)) dut_b (
        .clk(clk), .resetn(resetn),
        .wr_en(wr_en[1]), .wr_addr(wr_addr[1][2:0]), .wr_data(wr_data[1]), .wr_be(wr_be[1]),
        .rd_en(rd_en[1]), .rd_addr(rd_addr[1][2:0]),
        .rd_data(rd_data[1]), .rd_valid(rd_valid[1]),
        .err_oob(err_oob[1]), .err_sticky(err_sticky[1]), .err_clr(err_clr[1])
    );

    always #5 clk = ~clk;

    // Absolute time limit so the run can never hang.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle();
        for (int k = 0; k < 2; k++) begin
            wr_en[k] = 1'b0; wr_addr[k] = '0; wr_data[k] = '0; wr_be[k] = '0;
            rd_en[k] = 1'b0; rd_addr[k] = '0; err_clr[k] = 1'b0;
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        resetn = 1'b0;
        tick();
        tick();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({rd_data[k], rd_valid[k], err_oob[k], err_sticky[k]} !== 35'd0) begin
                errors++;
                $display("FAIL reset_outputs inst%0d got data=%h v=%b oob=%b st=%b exp all 0",
                         k, rd_data[k], rd_valid[k], err_oob[k], err_sticky[k]);
            end
        end
        resetn = 1'b1;
        wr_en[0] = 1'b1; wr_addr[0] = 4'd2; wr_data[0] = 32'h1234_5678; wr_be[0] = 4'hF;
        wr_en[1] = 1'b1; wr_addr[1] = 4'd1; wr_data[1] = 32'hCAFE_F00D; wr_be[1] = 4'hF;
        tick();
        idle();
        rd_en[0] = 1'b1; rd_addr[0] = 4'd2;
        tick();
        checks++;
        if (rd_valid[0] !== 1'b1 || rd_data[0] !== 32'h1234_5678) begin
            errors++;
            $display("FAIL pre_reset_read got v=%b data=%h exp v=1 data=12345678", rd_valid[0], rd_data[0]);
        end
        // A second read is in flight when reset asserts asynchronously.
        tick();
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if (rd_valid[0] !== 1'b0 || rd_data[0] !== 32'h0) begin
            errors++;
            $display("FAIL async_reset_discard got v=%b data=%h exp v=0 data=0", rd_valid[0], rd_data[0]);
        end
        tick();
        checks++;
        if (rd_valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL valid_during_reset got %b exp 0", rd_valid[0]);
        end
        idle();
        resetn = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rd_en[0] = 1'b1; rd_addr[0] = 4'(i);
            rd_en[1] = (i < 6); rd_addr[1] = (i < 6) ? 4'(i) : 4'd0;
            tick();
            checks++;
            if (rd_valid[0] !== 1'b1 || rd_data[0] !== 32'h0) begin
                errors++;
                $display("FAIL readback_zero_a addr=%0d got v=%b data=%h exp v=1 data=0", i, rd_valid[0], rd_data[0]);
            end
            if (i < 6) begin
                checks++;
                if (rd_valid[1] !== 1'b1 || rd_data[1] !== 32'h0) begin
                    errors++;
                    $display("FAIL readback_zero_b addr=%0d got v=%b data=%h exp v=1 data=0", i, rd_valid[1], rd_data[1]);
                end
            end
        end
        idle();
        tick();
    endtask

    task automatic test_byte_enables();
        wr_en[0] = 1'b1; wr_addr[0] = 4'd3; wr_data[0] = 32'hAABB_CCDD; wr_be[0] = 4'hF;
        tick();
        wr_data[0] = 32'h1122_3344; wr_be[0] = 4'b0101;
        tick();
        // All-zero byte enables must leave the word untouched and raise no error.
        wr_data[0] = 32'hFFFF_FFFF; wr_be[0] = 4'b0000;
        tick();
        checks++;
        if (err_oob[0] !== 1'b0 || err_sticky[0] !== 1'b0) begin
            errors++;
            $display("FAIL zero_be_no_error got oob=%b st=%b exp 0 0", err_oob[0], err_sticky[0]);
        end
        idle();
        rd_en[0] = 1'b1; rd_addr[0] = 4'd3;
        tick();
        checks++;
        if (rd_valid[0] !== 1'b1 || rd_data[0] !== 32'hAA22_CC44) begin
            errors++;
            $display("FAIL byte_merge got v=%b data=%h exp v=1 data=aa22cc44", rd_valid[0], rd_data[0]);
        end
        idle();
        tick();
    endtask

    task automatic test_collision();
        for (int k = 0; k < 2; k++) begin
            wr_en[k] = 1'b1; wr_addr[k] = 4'd5; wr_data[k] = 32'hDEAD_BEEF; wr_be[k] = 4'b0011;
            rd_en[k] = 1'b1; rd_addr[k] = 4'd5;
        end
        tick();
        checks++;
        if (rd_valid[0] !== 1'b1 || rd_data[0] !== 32'h0000_BEEF) begin
            errors++;
            $display("FAIL collision_write_through got v=%b data=%h exp v=1 data=0000beef", rd_valid[0], rd_data[0]);
        end
        checks++;
        if (rd_valid[1] !== 1'b1 || rd_data[1] !== 32'h0) begin
            errors++;
            $display("FAIL collision_read_old got v=%b data=%h exp v=1 data=0", rd_valid[1], rd_data[1]);
        end
        checks++;
        if (err_oob[0] !== 1'b0 || err_oob[1] !== 1'b0) begin
            errors++;
            $display("FAIL collision_no_error got oob=%b%b exp 00", err_oob[0], err_oob[1]);
        end
        idle();
        rd_en[1] = 1'b1; rd_addr[1] = 4'd5;
        tick();
        checks++;
        if (rd_data[1] !== 32'h0000_BEEF) begin
            errors++;
            $display("FAIL collision_write_completed got %h exp 0000beef", rd_data[1]);
        end
        idle();
        tick();
    endtask

    task automatic test_out_of_range();
        wr_en[1] = 1'b1; wr_addr[1] = 4'd7; wr_data[1] = 32'h55; wr_be[1] = 4'hF;
        tick();
        checks++;
        if (err_oob[1] !== 1'b1 || err_sticky[1] !== 1'b1) begin
            errors++;
            $display("FAIL oob_write_flags got oob=%b st=%b exp 1 1", err_oob[1], err_sticky[1]);
        end
        idle();
        tick();
        checks++;
        if (err_oob[1] !== 1'b0 || err_sticky[1] !== 1'b1) begin
            errors++;
            $display("FAIL oob_pulse_width got oob=%b st=%b exp 0 1", err_oob[1], err_sticky[1]);
        end
        for (int i = 0; i < 6; i++) begin
            logic [31:0] exp_word;
            exp_word = (i == 5) ? 32'h0000_BEEF : (i == 1) ? 32'h0 : 32'h0;
            rd_en[1] = 1'b1; rd_addr[1] = 4'(i);
            tick();
            checks++;
            if (rd_data[1] !== exp_word) begin
                errors++;
                $display("FAIL oob_write_no_change addr=%0d got %h exp %h", i, rd_data[1], exp_word);
            end
        end
        rd_addr[1] = 4'd6;
        tick();
        checks++;
        if (rd_valid[1] !== 1'b1 || rd_data[1] !== 32'h0 || err_oob[1] !== 1'b1) begin
            errors++;
            $display("FAIL oob_read got v=%b data=%h oob=%b exp 1 0 1", rd_valid[1], rd_data[1], err_oob[1]);
        end
        // Both ports out of range in one cycle yields a single one-cycle pulse.
        wr_en[1] = 1'b1; wr_addr[1] = 4'd7; wr_be[1] = 4'hF; rd_addr[1] = 4'd6;
        tick();
        idle();
        tick();
        checks++;
        if (err_oob[1] !== 1'b0) begin
            errors++;
            $display("FAIL oob_both_single_pulse got %b exp 0", err_oob[1]);
        end
        tick();
    endtask

    task automatic test_sticky_clear();
        rd_en[1] = 1'b1; rd_addr[1] = 4'd6; err_clr[1] = 1'b1;
        tick();
        checks++;
        if (err_sticky[1] !== 1'b1 || err_oob[1] !== 1'b1) begin
            errors++;
            $display("FAIL sticky_set_wins got st=%b oob=%b exp 1 1", err_sticky[1], err_oob[1]);
        end
        idle();
        err_clr[1] = 1'b1;
        tick();
        checks++;
        if (err_sticky[1] !== 1'b0) begin
            errors++;
            $display("FAIL sticky_clear got %b exp 0", err_sticky[1]);
        end
        idle();
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [4];
        for (int i = 0; i < 4; i++) begin
            vals[i] = $urandom;
            wr_en[0] = 1'b1; wr_addr[0] = 4'(i + 1); wr_data[0] = vals[i]; wr_be[0] = 4'hF;
            tick();
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            rd_en[0] = 1'b1; rd_addr[0] = 4'(i + 1);
            tick();
            checks++;
            if (rd_valid[0] !== 1'b1 || rd_data[0] !== vals[i]) begin
                errors++;
                $display("FAIL back_to_back addr=%0d got v=%b data=%h exp v=1 data=%h",
                         i + 1, rd_valid[0], rd_data[0], vals[i]);
            end
        end
        idle();
        tick();
        checks++;
        if (rd_valid[0] !== 1'b0 || rd_data[0] !== 32'h0) begin
            errors++;
            $display("FAIL idle_clears_read got v=%b data=%h exp 0 0", rd_valid[0], rd_data[0]);
        end
    endtask

    // Random traffic on both instances against a word-array reference model.
    task automatic test_random();
        logic [31:0] mdl [2][16];
        logic [31:0] e_data   [2];
        logic        e_valid  [2];
        logic        e_oob    [2];
        logic        e_sticky [2];
        int          dep [2];
        int          wt  [2];
        dep[0] = 16; dep[1] = 6;
        wt[0]  = 1;  wt[1]  = 0;
        idle();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        for (int k = 0; k < 2; k++) begin
            for (int a = 0; a < 16; a++) mdl[k][a] = '0;
            e_data[k] = '0; e_valid[k] = 1'b0; e_oob[k] = 1'b0; e_sticky[k] = 1'b0;
        end
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < 2; k++) begin
                wr_en[k]   = ($urandom_range(0, 2) != 0);
                wr_addr[k] = (k == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 7));
                wr_data[k] = $urandom;
                wr_be[k]   = 4'($urandom_range(0, 15));
                if (wr_be[k] == 4'h0 && wr_addr[k] >= 4'(dep[k])) wr_be[k] = 4'h1;
                rd_en[k]   = ($urandom_range(0, 3) != 0);
                rd_addr[k] = ($urandom_range(0, 3) == 0) ? wr_addr[k]
                           : ((k == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 7)));
                err_clr[k] = ($urandom_range(0, 7) == 0);
            end
            tick();
            for (int k = 0; k < 2; k++) begin
                logic rd_in, wr_in, oob;
                rd_in = int'(rd_addr[k]) < dep[k];
                wr_in = int'(wr_addr[k]) < dep[k];
                oob   = (wr_en[k] && !wr_in) || (rd_en[k] && !rd_in);
                e_valid[k] = rd_en[k];
                e_data[k]  = '0;
                if (rd_en[k] && rd_in) begin
                    e_data[k] = mdl[k][rd_addr[k]];
                    if (wt[k] == 1 && wr_en[k] && rd_addr[k] == wr_addr[k]) begin
                        for (int b = 0; b < 4; b++)
                            if (wr_be[k][b]) e_data[k][b*8 +: 8] = wr_data[k][b*8 +: 8];
                    end
                end
                if (wr_en[k] && wr_in) begin
                    for (int b = 0; b < 4; b++)
                        if (wr_be[k][b]) mdl[k][wr_addr[k]][b*8 +: 8] = wr_data[k][b*8 +: 8];
                end
                e_oob[k] = oob;
                if (oob) e_sticky[k] = 1'b1;
                else if (err_clr[k]) e_sticky[k] = 1'b0;
                checks++;
                if (rd_valid[k] !== e_valid[k] || rd_data[k] !== e_data[k] ||
                    err_oob[k] !== e_oob[k] || err_sticky[k] !== e_sticky[k]) begin
                    errors++;
                    $display("FAIL random inst%0d cyc%0d got v=%b d=%h oob=%b st=%b exp v=%b d=%h oob=%b st=%b",
                             k, n, rd_valid[k], rd_data[k], err_oob[k], err_sticky[k],
                             e_valid[k], e_data[k], e_oob[k], e_sticky[k]);
                end
            end
        end
        idle();
        tick();
    endtask

    initial begin
        idle();
        resetn = 1'b0;
        test_reset();
        test_byte_enables();
        test_collision();
        test_out_of_range();
        test_sticky_clear();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ff_mem_bank_be.md
Name: ff_mem_bank_be

Overview:
Parametrised flip-flop memory bank with one write port and one read port, usable in the same cycle. Writes use per-byte enables. The read port returns registered data with a valid strobe. Same-address collisions follow a configurable policy, and out-of-range accesses are flagged with a pulse and a sticky status bit. It is the general-purpose register-file/scratchpad for control paths that need small, fully resettable storage.

Parameters:
DATA_W, 32, word width in bits; must be a multiple of 8 (elaboration error otherwise)
DEPTH, 16, number of words; any value >= 2, need not be a power of two
ADDR_W, $clog2(DEPTH), address width; must satisfy 2**ADDR_W >= DEPTH
WRITE_THROUGH, 1, 1 = same-cycle same-address read returns new data; 0 = returns old data

Ports:
clk  input  1  clock; all state updates on rising edge
resetn  input  1  reset; asynchronous, active-low
wr_en  input  1  write request
wr_addr  input  ADDR_W  write address
wr_data  input  DATA_W  write data
wr_be  input  DATA_W/8  byte enables; bit i covers wr_data[8i+7:8i]
rd_en  input  1  read request
rd_addr  input  ADDR_W  read address
rd_data  output  DATA_W  registered read data
rd_valid  output  1  rd_data valid; high for one cycle per accepted read
err_oob  output  1  one-cycle pulse: an enabled access in the previous cycle had address >= DEPTH
err_sticky  output  1  latched out-of-range flag
err_clr  input  1  clears err_sticky

Behaviour:
- Reset (resetn low, asynchronous assert): all DEPTH words = 0, rd_data = 0, rd_valid = 0, err_oob = 0, err_sticky = 0. Deassertion takes effect at the next rising edge.
- Reset mid-operation: an in-flight read response is discarded (rd_valid forced 0). No partial writes remain; memory is fully zeroed.
- Write: at the edge with wr_en=1 and wr_addr < DEPTH, each lane i with wr_be[i]=1 takes wr_data lane i. Lanes with wr_be[i]=0 keep their value.
- wr_en=1 with wr_be all zero: no change and no error.
- Read latency is 1 cycle. At the edge with rd_en=1 and rd_addr < DEPTH: rd_data <= word, rd_valid <= 1.
- rd_en=0: rd_valid <= 0 and rd_data <= 0. rd_data is never stale-held.
- Back-to-back reads: one response per cycle, no bubbles.
- Collision (rd_en & wr_en, both in range, rd_addr == wr_addr):
  - WRITE_THROUGH=1: rd_data = byte-wise merge, taking new lanes where wr_be=1 and old lanes elsewhere.
  - WRITE_THROUGH=0: rd_data = pre-write word.
  - The write always completes. No error is raised; simultaneous read and write is legal.
- Out-of-range write (wr_en, wr_addr >= DEPTH): memory unchanged; err_oob <= 1 next cycle.
- Out-of-range read (rd_en, rd_addr >= DEPTH): rd_valid <= 1, rd_data <= 0, err_oob <= 1 next cycle. The requester always gets a response.
- Both ports out of range in the same cycle: a single err_oob pulse.
- err_oob is registered and high for exactly one cycle per offending edge; consecutive offending cycles hold it high.
- err_sticky sets on any condition that sets err_oob. err_clr=1 clears it at the edge. When set and clear occur in the same cycle, set wins.
- Addresses are never wrapped or truncated modulo DEPTH.
- No combinational path from inputs to outputs.

Test Plan:
- Reset/readback (DATA_W=32, DEPTH=16): resetn low mid-sequence, release, read addr 0..15 -> each rd_data=0x00000000, rd_valid=1 one cycle after each rd_en; rd_valid=0 during reset.
- Byte enables: write 0xAABBCCDD be=4'hF to addr 3, then 0x11223344 be=4'b0101 to addr 3, read addr 3 -> 0xAA22CC44.
- Collision, WRITE_THROUGH=1: addr 5 holds 0x0; same cycle write 0xDEADBEEF be=4'b0011 and read addr 5 -> rd_data=0x0000BEEF next cycle. With WRITE_THROUGH=0 -> 0x00000000, and a following read gives 0x0000BEEF.
- Out of range (DEPTH=6, ADDR_W=3): write addr 7 data 0x55 -> err_oob pulse for 1 cycle, err_sticky=1, and addrs 0..5 unchanged. Read addr 6 -> rd_valid=1, rd_data=0, err_oob=1.
- Sticky clear priority: err_clr=1 in the same cycle as an out-of-range read -> err_sticky stays 1. err_clr=1 alone next cycle -> err_sticky=0.
- Throughput/idle: rd_en high for 4 cycles on addrs 1,2,3,4 -> four consecutive rd_valid=1 with matching data. rd_en low -> rd_valid=0 and rd_data=0 next cycle.
